// File: rtl/parity_frame_ctrl_if.sv
// Client-side bus of parity_frame_ctrl: word requests, serial frame stream and tagged parity result.
interface parity_frame_ctrl_if #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 32
);
   localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic                  ser_bit;
   logic                  ser_valid;
   logic                  ser_first;
   logic                  ser_last;
   logic                  res_valid;
   logic                  res_parity;
   logic [IDW-1:0]        res_id;
   logic                  res_ready;
   logic                  busy;

   modport master (
      output req_valid, req_data, res_ready,
      input  req_ready, ser_bit, ser_valid, ser_first, ser_last,
      input  res_valid, res_parity, res_id, busy
   );

   modport slave (
      input  req_valid, req_data, res_ready,
      output req_ready, ser_bit, ser_valid, ser_first, ser_last,
      output res_valid, res_parity, res_id, busy
   );
endinterface

// File: rtl/parity_frame_ctrl.sv
// Arbitrates NREQ word clients, shifts the granted word out LSB-first and returns its even parity with the owner id.
// Define ARB_RR_EN for round-robin arbitration; default is fixed priority (lowest index wins).
module parity_frame_ctrl #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 32
) (
   input logic                clk,
   input logic                rst_n,
   parity_frame_ctrl_if.slave bus
);
   localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CW  = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] shreg_q;
   logic [CW-1:0]    cnt_q;
   logic             acc_q;
   logic [IDW-1:0]   id_q;

   logic [IDW-1:0]   start_idx;
   logic [IDW-1:0]   cand;
   logic [IDW-1:0]   grant;
   logic             found;
   logic             fire;
   logic [WIDTH-1:0] word;

   // Arbitration search origin: rotating pointer or fixed at requester 0.
`ifdef ARB_RR_EN
   logic [IDW-1:0] ptr_q;

   assign start_idx = ptr_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (fire) begin
         ptr_q <= (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
      end
   end
`else
   assign start_idx = '0;
`endif

   // First asserted request found walking upward from start_idx, wrapping at NREQ.
   always_comb begin
      cand  = '0;
      grant = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = IDW'((32'(start_idx) + k) % NREQ);
         if (!found && bus.req_valid[cand]) begin
            found = 1'b1;
            grant = cand;
         end
      end
   end

   assign fire = rst_n && (state_q == IDLE) && found;

   always_comb begin
      word = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant == IDW'(i)) begin
            word = bus.req_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (fire)            state_d = SHIFT;
         SHIFT:   if (cnt_q == LAST)   state_d = DONE;
         DONE:    if (bus.res_ready)   state_d = IDLE;
         default:                      state_d = IDLE;
      endcase
   end

   // Output decode; only req_ready looks at live inputs.
   always_comb begin
      bus.req_ready  = '0;
      bus.ser_bit    = 1'b0;
      bus.ser_valid  = 1'b0;
      bus.ser_first  = 1'b0;
      bus.ser_last   = 1'b0;
      bus.res_valid  = 1'b0;
      bus.res_parity = 1'b0;
      bus.res_id     = '0;
      bus.busy       = 1'b1;
      case (state_q)
         IDLE: begin
            bus.busy = 1'b0;
            if (fire) begin
               bus.req_ready[grant] = 1'b1;
            end
         end
         SHIFT: begin
            bus.ser_valid = 1'b1;
            bus.ser_bit   = shreg_q[0];
            bus.ser_first = (cnt_q == '0);
            bus.ser_last  = (cnt_q == LAST);
         end
         DONE: begin
            bus.res_valid  = 1'b1;
            bus.res_parity = acc_q;
            bus.res_id     = id_q;
         end
         default: begin
            bus.busy = 1'b1;
         end
      endcase
   end

   // Frame datapath: capture on accept, shift and accumulate parity while serializing.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shreg_q <= '0;
         cnt_q   <= '0;
         acc_q   <= 1'b0;
         id_q    <= '0;
      end else if (fire) begin
         shreg_q <= word;
         cnt_q   <= '0;
         acc_q   <= 1'b0;
         id_q    <= grant;
      end else if (state_q == SHIFT) begin
         acc_q   <= acc_q ^ shreg_q[0];
         shreg_q <= {1'b0, shreg_q[WIDTH-1:1]};
         if (cnt_q != LAST) begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

endmodule

// File: doc/parity_frame_ctrl.md
# parity_frame_ctrl

Multi-requester frame scheduler for the serial parity datapath. It arbitrates up to NREQ clients that each present a WIDTH-bit word, serializes the granted word LSB-first as a framed bit stream, and accumulates the even parity of that frame. It returns the parity tagged with the requester index. It sits between the word-oriented client logic and the serial parity generator, and sequences one frame at a time.

## Interface
- NREQ, 4: number of requesters; legal range 2..8.
- WIDTH, 32: frame length in bits; legal range 2..64.
- IDW, $clog2(NREQ): width of the requester index.
- clk  input  1  single clock; all logic on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req_valid  input  NREQ  per-requester word-valid.
- req_data  input  NREQ*WIDTH  packed words; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  output  NREQ  one-hot accept; at most one bit high.
- ser_bit  output  1  current serial data bit.
- ser_valid  output  1  ser_bit is a frame bit this cycle.
- ser_first  output  1  first bit of the frame (bit 0).
- ser_last  output  1  last bit of the frame (bit WIDTH-1).
- res_valid  output  1  parity result available.
- res_parity  output  1  XOR of all WIDTH bits of the frame (even parity bit).
- res_id  output  IDW  index of the requester that owned the frame.
- res_ready  input  1  consumer accepts the result.
- busy  output  1  high in every state other than IDLE.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - The arbiter selects grant g among asserted req_valid bits.
  - req_ready[g] is driven combinationally from req_valid while in IDLE. All other req_ready bits are low.
  - On req_valid[g] & req_ready[g]: capture req_data word g into the shift register and g into id_q, clear the parity accumulator and bit counter, then go to SHIFT.
  - With no valid request, remain in IDLE.
- SHIFT:
  - Each cycle: ser_valid=1 and ser_bit=shreg[0].
  - Each cycle: the accumulator takes accumulator ^ shreg[0], shreg shifts right by one, and the counter increments.
  - ser_first=1 when counter==0. ser_last=1 when counter==WIDTH-1.
  - On the ser_last cycle, go to DONE.
  - The counter is $clog2(WIDTH) bits wide and never wraps within a frame.
- DONE:
  - res_valid=1, res_parity=accumulator, res_id=id_q. These hold stable while res_ready is low.
  - On res_ready, go to IDLE.
  - No request is accepted in DONE, so req_ready=0.
- Arbiter:
  - Grant is evaluated only in IDLE.
  - Requests that arrive during SHIFT or DONE wait. req_data must be held stable by the client only until its accept cycle.
- Reset (rst_n low at a clock edge) clears the following to 0:
  - state goes to IDLE;
  - shreg, counter, accumulator, id_q;
  - the round-robin pointer.
- Reset mid-frame aborts the frame. No res_valid is produced for it, and the aborted requester must re-request.

## Timing
- Reset values: req_ready=0 (while rst_n is low), ser_bit=0, ser_valid=0, ser_first=0, ser_last=0, res_valid=0, res_parity=0, res_id=0, busy=0.
- All serial and result outputs are registered or decoded from registered state only. Only req_ready depends combinationally on req_valid.
- Latency:
  - Accept edge at cycle T.
  - Frame bits appear on cycles T+1 .. T+WIDTH.
  - res_valid asserts on cycle T+WIDTH+1.
- Minimum frame period is WIDTH+2 cycles (accept, WIDTH shift cycles, 1 DONE cycle with res_ready=1).
- If res_ready is already high on the first DONE cycle, the result is consumed that cycle and IDLE is re-entered on the next cycle.
- Simultaneous requests are resolved in a single cycle. The losing requests stay pending with no loss.
- If req_valid drops before an accept, no transfer occurs.

## Configuration
- ARB_RR_EN defined: round-robin arbitration.
  - The pointer advances to (g+1) mod NREQ after each accept.
  - The search starts at the pointer.
  - After reset the pointer is 0, so requester 0 has priority first.
- ARB_RR_EN undefined: fixed priority, lowest index wins. The pointer logic is absent.

## Test plan
- Reset values: hold rst_n=0 for 3 cycles with req_valid=4'b1111 -> all outputs 0, req_ready=0. After release, req_ready=4'b0001 in the first IDLE cycle.
- Single frame: requester 2 sends 32'hA5A5_0001 -> ser_bit sequence 1,0,0,…,1 LSB-first over 32 cycles, ser_first on cycle 1, ser_last on cycle 32. Then res_valid with res_parity=1 and res_id=2 on cycle 33.
- Even-parity frame: requester 0 sends 32'hFFFF_FFFF -> res_parity=0. Requester 1 sends 32'h0000_0000 -> res_parity=0. Requester 3 sends 32'h8000_0000 -> res_parity=1.
- Contention: all four requesters valid continuously.
  - With ARB_RR_EN, grant order is 0,1,2,3,0.
  - Without ARB_RR_EN, requester 0 is granted every frame.
  - Frame period is 34 cycles with res_ready tied high.
- Backpressure: hold res_ready=0 for 10 cycles in DONE -> res_valid, res_parity and res_id stay stable, and req_ready=0 throughout. Release res_ready -> IDLE on the next cycle.
- Mid-frame reset: assert rst_n=0 at shift bit 17 -> next cycle ser_valid=0 and busy=0, and no res_valid ever appears for that frame. A following request completes normally.
